// File: rtl/sine_table_loader_pkg.sv
// Shared constants and state encoding for the DDS waveform-table loader.
package sine_table_loader_pkg;

  localparam logic [7:0] LOADER_HEADER  = 8'hA5;
  localparam int         DATA_LEN       = 11;
  localparam int         ROWS_BASE_2    = 4;
  localparam int         MEMORY_HEIGHT  = 16;
  localparam int         LOADER_TIMEOUT = 50000;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_CNT,
    LDR_HI,
    LDR_LO,
    LDR_WR,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERR
  } ldr_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte watchdog: counts idle cycles while armed, restarts on clear or when disarmed.
module loader_watchdog #(
  parameter int TIMEOUT = 50000
) (
  input  logic src_clk,
  input  logic rst,
  input  logic clear,
  input  logic arm,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear || !arm) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = arm && (count_reg == CW'(TIMEOUT));

endmodule

// File: rtl/sine_table_loader.sv
// Writer side of the DDS waveform table: unpacks a framed byte stream into sequential row writes.
// Define TABLE_LOADER_CSUM_EN to require and check a trailing XOR checksum byte per frame.
module sine_table_loader
  import sine_table_loader_pkg::*;
#(
  parameter int         DATA_W  = DATA_LEN,
  parameter int         ADDR_W  = ROWS_BASE_2,
  parameter int         DEPTH   = MEMORY_HEIGHT,
  parameter logic [7:0] HEADER  = LOADER_HEADER,
  parameter int         TIMEOUT = LOADER_TIMEOUT
) (
  input  logic              src_clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] data_wr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              we,
  output logic              dds_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   entries
);

`ifdef TABLE_LOADER_CSUM_EN
  localparam ldr_state_t AFTER_LAST = LDR_CSUM;
`else
  localparam ldr_state_t AFTER_LAST = LDR_DONE;
`endif

  ldr_state_t        state_reg, state_next;
  logic              ready_en_reg;
  logic [7:0]        hi_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] row_reg, last_row_reg;
  logic              hold_reg, done_reg, err_reg;
  logic [ADDR_W:0]   entries_reg;

  logic       accept, header_seen, in_frame, expired, too_many, last_row;
  logic [8:0] n_words;

  // rx_ready stays low for the first cycle out of reset and during every write cycle.
  assign rx_ready    = ready_en_reg && (state_reg != LDR_WR);
  assign accept      = rx_valid && rx_ready;
  assign header_seen = accept && (rx_data == HEADER) &&
                       (state_reg inside {LDR_IDLE, LDR_DONE, LDR_ERR});
  assign in_frame    = state_reg inside {LDR_CNT, LDR_HI, LDR_LO, LDR_CSUM};
  assign n_words     = {1'b0, rx_data} + 9'd1;
  assign too_many    = n_words > 9'(DEPTH);
  assign last_row    = row_reg == last_row_reg;

  loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .src_clk (src_clk),
    .rst     (rst),
    .clear   (accept),
    .arm     (in_frame),
    .expired (expired)
  );

`ifdef TABLE_LOADER_CSUM_EN
  logic [7:0] csum_reg;
  logic       csum_ok;

  assign csum_ok = rx_data == csum_reg;

  // Checksum covers CNT and all payload bytes, never the header.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      csum_reg <= '0;
    end else if (header_seen) begin
      csum_reg <= '0;
    end else if (accept && (state_reg inside {LDR_CNT, LDR_HI, LDR_LO})) begin
      csum_reg <= csum_reg ^ rx_data;
    end
  end
`endif

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) state_reg <= LDR_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LDR_IDLE, LDR_DONE, LDR_ERR: if (header_seen) state_next = LDR_CNT;
      LDR_CNT:  if (accept) state_next = too_many ? LDR_ERR : LDR_HI;
      LDR_HI:   if (accept) state_next = LDR_LO;
      LDR_LO:   if (accept) state_next = LDR_WR;
      LDR_WR:   state_next = last_row ? AFTER_LAST : LDR_HI;
`ifdef TABLE_LOADER_CSUM_EN
      LDR_CSUM: if (accept) state_next = csum_ok ? LDR_DONE : LDR_ERR;
`endif
      default:  state_next = LDR_IDLE;
    endcase
    // A byte landing on the expiry cycle still counts as progress.
    if (expired && !accept) state_next = LDR_ERR;
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      ready_en_reg <= 1'b0;
      hi_reg       <= '0;
      data_reg     <= '0;
      row_reg      <= '0;
      last_row_reg <= '0;
      hold_reg     <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      entries_reg  <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept && state_reg == LDR_CNT) last_row_reg <= rx_data[ADDR_W-1:0];
      if (accept && state_reg == LDR_HI)  hi_reg <= rx_data;
      if (accept && state_reg == LDR_LO)  data_reg <= DATA_W'({hi_reg, rx_data});

      if (header_seen)               row_reg <= '0;
      else if (state_reg == LDR_WR)  row_reg <= row_reg + 1'b1;

      // Entries only moves on success, so an aborted frame leaves the old count.
      if (header_seen) begin
        hold_reg <= 1'b1;
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
      end else if (state_next == LDR_DONE && state_reg != LDR_DONE) begin
        hold_reg    <= 1'b0;
        done_reg    <= 1'b1;
        entries_reg <= {1'b0, last_row_reg} + 1'b1;
      end else if (state_next == LDR_ERR && state_reg != LDR_ERR) begin
        hold_reg <= 1'b1;
        done_reg <= 1'b0;
        err_reg  <= 1'b1;
      end
    end
  end

  assign we        = state_reg == LDR_WR;
  assign data_wr   = data_reg;
  assign addr_wr   = row_reg;
  assign dds_hold  = hold_reg;
  assign load_done = done_reg;
  assign load_err  = err_reg;
  assign entries   = entries_reg;

endmodule
